// File: rtl/buff_pkg.sv
// Shared types and CRC-8 helper for the frame buffer device.
// CRC-8: polynomial 0x07, MSB first, one byte per call.
package buff_pkg;

    localparam int FB_DEPTH = 16;
    localparam int FB_AW    = 4;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        READY = 2'd2,
        SEND  = 2'd3
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Payload byte store: synchronous write, combinational read, one port of each.
module fb_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/frame_buffer_device.sv
// Captures one start/stop framed block, checks its CRC-8, holds it and
// replays it on request with startoutput/stopoutput framing.
module frame_buffer_device
    import buff_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = FB_AW
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] datain,
    input  logic       start_read,
    output logic [7:0] dataout,
    output logic       startoutput,
    output logic       stopoutput,
    output logic       frame_ready,
    output logic       crc_err,
    output logic       frame_err
);

    state_t      r_state, w_state_next;
    logic [AW:0] r_len, w_len_next;
    logic [AW:0] r_cnt, w_cnt_next;
    logic [7:0]  r_crc, w_crc_next;
    logic [7:0]  r_dataout, w_dataout_next;
    logic        r_sop, w_sop_next;
    logic        r_eop, w_eop_next;
    logic        r_frame_ready, w_frame_ready_next;
    logic        r_crc_err, w_crc_err_next;
    logic        r_frame_err, w_frame_err_next;

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_rd_data;
    logic          w_len_ok;

    fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (datain),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // In RECV r_cnt is the payload count; in SEND it is the replay byte index.
    assign w_wr_addr = r_cnt[AW-1:0];
    assign w_rd_addr = r_cnt[AW-1:0] - AW'(1);
    assign w_len_ok  = (datain != 8'd0) && (datain <= 8'(DEPTH));

    always_comb begin
        w_state_next     = r_state;
        w_len_next       = r_len;
        w_cnt_next       = r_cnt;
        w_crc_next       = r_crc;
        w_dataout_next   = r_dataout;
        w_sop_next       = 1'b0;
        w_eop_next       = 1'b0;
        w_crc_err_next   = 1'b0;
        w_frame_err_next = 1'b0;
        w_wr_en          = 1'b0;

        // A new start wins from IDLE, RECV and READY alike; only SEND ignores it.
        if (r_state != SEND && start) begin
            if (stop || !w_len_ok) begin
                w_frame_err_next = 1'b1;
                w_state_next     = IDLE;
            end else begin
                w_state_next = RECV;
                w_len_next   = datain[AW:0];
                w_cnt_next   = '0;
                w_crc_next   = crc8_step(8'h00, datain);
            end
        end else begin
            case (r_state)
                RECV: begin
                    if (stop) begin
                        w_state_next = IDLE;
                        if (r_cnt != r_len) begin
                            w_frame_err_next = 1'b1;
                        end else if (datain != r_crc) begin
                            w_crc_err_next = 1'b1;
                        end else begin
                            w_state_next = READY;
                        end
                    end else if (r_cnt == r_len) begin
                        // CRC slot reached without stop: late stop
                        w_frame_err_next = 1'b1;
                        w_state_next     = IDLE;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_cnt_next = r_cnt + (AW+1)'(1);
                        w_crc_next = crc8_step(r_crc, datain);
                    end
                end
                READY: begin
                    if (start_read) begin
                        w_state_next = SEND;
                        w_cnt_next   = '0;
                    end
                end
                SEND: begin
                    w_cnt_next = r_cnt + (AW+1)'(1);
                    if (r_cnt == '0) begin
                        w_dataout_next = 8'(r_len);
                        w_sop_next     = 1'b1;
                        w_crc_next     = crc8_step(8'h00, 8'(r_len));
                    end else if (r_cnt <= r_len) begin
                        w_dataout_next = w_rd_data;
                        w_crc_next     = crc8_step(r_crc, w_rd_data);
                    end else begin
                        w_dataout_next = r_crc;
                        w_eop_next     = 1'b1;
                        w_state_next   = IDLE;
                    end
                end
                default: ;
            endcase
        end

        w_frame_ready_next = (w_state_next == READY);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_len         <= '0;
            r_cnt         <= '0;
            r_crc         <= '0;
            r_dataout     <= '0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_frame_ready <= 1'b0;
            r_crc_err     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_len         <= w_len_next;
            r_cnt         <= w_cnt_next;
            r_crc         <= w_crc_next;
            r_dataout     <= w_dataout_next;
            r_sop         <= w_sop_next;
            r_eop         <= w_eop_next;
            r_frame_ready <= w_frame_ready_next;
            r_crc_err     <= w_crc_err_next;
            r_frame_err   <= w_frame_err_next;
        end
    end

    assign dataout     = r_dataout;
    assign startoutput = r_sop;
    assign stopoutput  = r_eop;
    assign frame_ready = r_frame_ready;
    assign crc_err     = r_crc_err;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_frame_buffer_device.sv
// Directed bench for frame_buffer_device: capture, CRC/framing errors,
// full-depth replay, restart, start during replay and asynchronous reset.
module tb_frame_buffer_device;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [7:0] datain;
    logic       start_read;
    logic [7:0] dataout;
    logic       startoutput;
    logic       stopoutput;
    logic       frame_ready;
    logic       crc_err;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] pay [0:15];
    logic [7:0] crc16;

    frame_buffer_device dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .datain      (datain),
        .start_read  (start_read),
        .dataout     (dataout),
        .startoutput (startoutput),
        .stopoutput  (stopoutput),
        .frame_ready (frame_ready),
        .crc_err     (crc_err),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Bit-serial CRC-8 (poly 0x07, MSB first), used for the full-depth frame.
    function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic [7:0] d, input logic rd);
        start      = s;
        stop       = p;
        datain     = d;
        start_read = rd;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        stop       = 1'b0;
        datain     = 8'h00;
        start_read = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len_b, input int npay, input logic [7:0] crc_b);
        drive(1'b1, 1'b0, len_b, 1'b0);
        for (int i = 0; i < npay; i++) drive(1'b0, 1'b0, pay[i], 1'b0);
        drive(1'b0, 1'b1, crc_b, 1'b0);
        idle_inputs();
    endtask

    task automatic replay(input int len, input logic [7:0] crc_b, input bit inject);
        logic [7:0] exp;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk1("ready_drop", frame_ready, 1'b0);
        start_read = 1'b0;
        for (int k = 0; k <= len + 1; k++) begin
            if (inject && k == 1) begin
                start  = 1'b1;
                datain = 8'h02;
            end else begin
                start  = 1'b0;
                datain = 8'h00;
            end
            @(posedge clock);
            #1;
            if (k == 0) exp = 8'(len);
            else if (k == len + 1) exp = crc_b;
            else exp = pay[k-1];
            chk8($sformatf("dout[%0d]", k), dataout, exp);
            chk1($sformatf("sop[%0d]", k), startoutput, k == 0);
            chk1($sformatf("eop[%0d]", k), stopoutput, k == len + 1);
        end
        idle_inputs();
        @(posedge clock);
        #1;
        chk8("dout_hold", dataout, crc_b);
        chk1("sop_after", startoutput, 1'b0);
        chk1("eop_after", stopoutput, 1'b0);
        chk1("ready_after", frame_ready, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #12;
        chk8("rst_dout", dataout, 8'h00);
        chk1("rst_sop", startoutput, 1'b0);
        chk1("rst_eop", stopoutput, 1'b0);
        chk1("rst_ready", frame_ready, 1'b0);
        chk1("rst_crcerr", crc_err, 1'b0);
        chk1("rst_frmerr", frame_err, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Good L=3 frame: CRC over 03 11 22 33 is 0xEE
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'd3, 3, 8'hEE);
        chk1("t1_ready", frame_ready, 1'b1);
        chk1("t1_crcerr", crc_err, 1'b0);
        chk1("t1_frmerr", frame_err, 1'b0);
        replay(3, 8'hEE, 1'b0);

        // Corrupted CRC byte
        send_frame(8'd3, 3, 8'hEF);
        chk1("t2_crcerr", crc_err, 1'b1);
        chk1("t2_ready", frame_ready, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk1("t2_crcerr_pulse", crc_err, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        idle_inputs();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk1("t2_rd_ignored", startoutput, 1'b0);
        chk1("t2_ready2", frame_ready, 1'b0);

        // L=4 with stop on the 4th payload byte (one early)
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        send_frame(8'd4, 3, 8'h04);
        chk1("t3_frmerr", frame_err, 1'b1);
        chk1("t3_ready", frame_ready, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk1("t3_frmerr_pulse", frame_err, 1'b0);

        // L=0, L=DEPTH+1, start with stop
        drive(1'b1, 1'b0, 8'd0, 1'b0);
        idle_inputs();
        chk1("t4_len0", frame_err, 1'b1);
        drive(1'b1, 1'b0, 8'd17, 1'b0);
        idle_inputs();
        chk1("t5_len17", frame_err, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk1("t5_pulse", frame_err, 1'b0);
        drive(1'b1, 1'b1, 8'd3, 1'b0);
        idle_inputs();
        chk1("t5_startstop", frame_err, 1'b1);
        chk1("t5_ready", frame_ready, 1'b0);

        // Full-depth frame
        for (int i = 0; i < 16; i++) pay[i] = 8'(i * 17) ^ 8'h5A;
        crc16 = crc_model(8'h00, 8'd16);
        for (int i = 0; i < 16; i++) crc16 = crc_model(crc16, pay[i]);
        send_frame(8'd16, 16, crc16);
        chk1("t6_ready", frame_ready, 1'b1);
        chk1("t6_frmerr", frame_err, 1'b0);
        replay(16, crc16, 1'b0);

        // Start mid-RECV: only the second frame (02 AA 55, CRC 0xE0) survives
        drive(1'b1, 1'b0, 8'd3, 1'b0);
        drive(1'b0, 1'b0, 8'h11, 1'b0);
        drive(1'b0, 1'b0, 8'h22, 1'b0);
        pay[0] = 8'hAA; pay[1] = 8'h55;
        send_frame(8'd2, 2, 8'hE0);
        chk1("t7_ready", frame_ready, 1'b1);
        chk1("t7_crcerr", crc_err, 1'b0);
        chk1("t7_frmerr", frame_err, 1'b0);
        replay(2, 8'hE0, 1'b0);

        // Start during SEND is ignored
        send_frame(8'd2, 2, 8'hE0);
        chk1("t8_ready", frame_ready, 1'b1);
        replay(2, 8'hE0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        idle_inputs();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk1("t8_no_capture", startoutput, 1'b0);
        chk1("t8_ready", frame_ready, 1'b0);

        // Asynchronous reset in the middle of a replay
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'd3, 3, 8'hEE);
        chk1("t9_ready", frame_ready, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        start_read = 1'b0;
        @(posedge clock);
        #1;
        chk1("t9_sop", startoutput, 1'b1);
        @(posedge clock);
        #1;
        chk8("t9_dout_pre", dataout, 8'h11);
        #2;
        reset = 1'b1;
        #1;
        chk8("t9_rst_dout", dataout, 8'h00);
        chk1("t9_rst_sop", startoutput, 1'b0);
        chk1("t9_rst_eop", stopoutput, 1'b0);
        chk1("t9_rst_ready", frame_ready, 1'b0);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk8("t9_idle_dout", dataout, 8'h00);
        chk1("t9_idle_eop", stopoutput, 1'b0);
        pay[0] = 8'hAA; pay[1] = 8'h55;
        send_frame(8'd2, 2, 8'hE0);
        chk1("t9_ready2", frame_ready, 1'b1);
        replay(2, 8'hE0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
